btn_event: RTL
==============

# btn_event

Converts the debounced push-button level from the debounce stage into single-cycle event pulses: press, release, long-press and optional auto-repeat. It also reports the measured hold duration. The block runs on the same 1 ms tick clock as the debounce stage, so every count is in milliseconds. Its outputs feed the display/LED control logic directly as one-cycle strobes.

## Interface
- `LONG_MS`, default 500: number of high samples, counted from the press edge, that qualifies a long press; legal range 2 to 2^CW-1.
- `REPEAT_MS`, default 100: interval between auto-repeat pulses once long-press is reached; legal range 1 to 2^CW-1.
- `CW`, default 10: width of the internal interval counter.
- `DW`, default 16: width of `hold_ms`.
- `clk_1ms` in 1: 1 ms tick clock; all logic on the rising edge.
- `rst_n` in 1: synchronous active-low reset.
- `btn_lvl` in 1: debounced button level from the debounce stage; already synchronous to `clk_1ms`.
- `press` out 1: one-cycle pulse on the press (rising) edge.
- `release_p` out 1: one-cycle pulse on the release (falling) edge.
- `long_press` out 1: one-cycle pulse when the hold reaches `LONG_MS`.
- `repeat_p` out 1: one-cycle auto-repeat pulse.
- `held` out 1: level, high in state PRESSED or LONG.
- `hold_ms` out DW: hold duration of the last completed press, in ms; saturating.

## Operation
- Input handling:
  - `btn_lvl` is registered into `prev` each edge.
  - Rise = `btn_lvl & ~prev`; fall = `~btn_lvl & prev`.
  - No extra synchronizer is used.
- State machine IDLE / PRESSED / LONG:
  - IDLE, on rise: go to PRESSED; `press`=1; `cnt`=1; `dur`=1.
  - PRESSED, `btn_lvl`=1 and `cnt`==LONG_MS-1: go to LONG; `long_press`=1; `cnt`=0; `dur`++.
  - PRESSED, `btn_lvl`=1 otherwise: `cnt`++; `dur`++.
  - LONG, `btn_lvl`=1 and `cnt`==REPEAT_MS-1: `repeat_p`=1 (only with the macro); `cnt`=0; `dur`++.
  - LONG, `btn_lvl`=1 otherwise: `cnt`++; `dur`++.
  - PRESSED or LONG, on fall: go to IDLE; `release_p`=1; `hold_ms`<=`dur`; `cnt`=0.
- `dur` counts the edges at which `btn_lvl` was sampled high, from the press edge to the last high edge inclusive. It saturates at 2^DW-1 and never wraps.
- `hold_ms` holds its value until the next release. A new press does not clear it.
- Simultaneous events: a fall always wins. If `btn_lvl` drops at the edge where the threshold would be reached, only `release_p` fires; no `long_press` or `repeat_p`.
- All pulse outputs are registered, last exactly one cycle, and are mutually exclusive in any cycle.
- `held` is registered: high from the press edge up to, but not including, the release edge.

## Timing
- Latency: each pulse is high in the cycle that starts at the edge where the triggering `btn_lvl` value is first sampled. That is one register stage from input to output.
- Taking the press edge as edge 0:
  - `long_press` occurs at edge LONG_MS-1.
  - Repeats occur at edges LONG_MS-1+k·REPEAT_MS, for k ≥ 1.
- Reset values: state IDLE; `prev`=0; `cnt`=0; `dur`=0; `press`=`release_p`=`long_press`=`repeat_p`=0; `held`=0; `hold_ms`=0.
- If `btn_lvl`=1 when `rst_n` is deasserted, the first edge with `rst_n`=1 sees a rise and generates `press`.
- Reset asserted mid-hold: all outputs return to their reset values on that edge. No `release_p` is emitted and `hold_ms` is not updated.

## Configuration
- `BTN_REPEAT_EN` defined: auto-repeat as described.
- `BTN_REPEAT_EN` undefined:
  - `repeat_p` is constant 0.
  - `REPEAT_MS` is ignored.
  - LONG keeps counting `dur`; `cnt` is held at 0.
  - `press`, `release_p`, `long_press` and `hold_ms` behave identically to the defined case.

## Test plan
- Reset: hold `rst_n`=0 with `btn_lvl` toggling → all outputs 0 and `hold_ms`=0 throughout.
- Short press, defaults: `btn_lvl` high for 20 edges → `press` at edge 0, `release_p` at edge 20, no `long_press`, `hold_ms`=20, `held` high for 20 cycles.
- Long press with repeat (`LONG_MS`=500, `REPEAT_MS`=100, macro defined): hold high for 750 edges → `long_press` at edge 499, `repeat_p` at 599 and 699, `release_p` at 750, `hold_ms`=750.
- Boundary: `btn_lvl` high for exactly 499 edges → `release_p` at edge 499, no `long_press`, `hold_ms`=499.
- Saturation and macro off (`DW`=4, `BTN_REPEAT_EN` undefined, `LONG_MS`=5): hold 20 edges → `long_press` at edge 4, `repeat_p` never asserted, `hold_ms`=15.
- Reset mid-hold: press, then `rst_n`=0 at edge 300 while high → no `release_p`, `hold_ms` keeps its prior value 0, `held`=0.

Source files
------------

// File: rtl/btn_event.sv
// btn_event: turns the debounced push-button level into one-cycle event
// strobes (press, release, long-press, optional auto-repeat). It also reports
// the hold duration of the last completed press. Every count is in
// milliseconds because the block runs on the 1 ms tick clock.
//
// Build option: define BTN_REPEAT_EN to enable auto-repeat pulses. When the
// macro is undefined, repeat_p is tied low and REPEAT_MS is not used.
//
// Parameters:
//   LONG_MS   high samples from the press edge that qualify a long press (2..2^CW-1)
//   REPEAT_MS interval between auto-repeat pulses after long press   (1..2^CW-1)
//   CW        interval counter width
//   DW        hold_ms width
//
// Ports:
//   clk_1ms    in   1 ms tick clock, rising edge
//   rst_n      in   synchronous active-low reset
//   btn_lvl    in   debounced button level, already synchronous to clk_1ms
//   press      out  one-cycle pulse on the press edge
//   release_p  out  one-cycle pulse on the release edge
//   long_press out  one-cycle pulse when the hold reaches LONG_MS
//   repeat_p   out  one-cycle auto-repeat pulse
//   held       out  high while the button is considered pressed
//   hold_ms    out  saturating hold duration of the last completed press
module btn_event #(
  parameter int LONG_MS   = 500,
  parameter int REPEAT_MS = 100,
  parameter int CW        = 10,
  parameter int DW        = 16
) (
  input  logic          clk_1ms,
  input  logic          rst_n,
  input  logic          btn_lvl,
  output logic          press,
  output logic          release_p,
  output logic          long_press,
  output logic          repeat_p,
  output logic          held,
  output logic [DW-1:0] hold_ms
);

  if (LONG_MS < 2 || LONG_MS > (2**CW) - 1 ||
      REPEAT_MS < 1 || REPEAT_MS > (2**CW) - 1) begin : g_bad_param
    $error("btn_event: LONG_MS/REPEAT_MS outside the range representable in CW bits");
  end

  typedef enum logic [1:0] {
    S_IDLE,
    S_PRESSED,
    S_LONG
  } state_t;

  localparam logic [CW-1:0] LONG_M1 = CW'(LONG_MS - 1);
`ifdef BTN_REPEAT_EN
  localparam logic [CW-1:0] REP_M1  = CW'(REPEAT_MS - 1);
`endif

  state_t        state_q, state_d;
  logic          prev_q;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [DW-1:0] dur_q, dur_d;
  logic [DW-1:0] hold_q, hold_d;
  logic [DW-1:0] dur_inc;
  logic          press_q, press_d;
  logic          rel_q, rel_d;
  logic          long_q, long_d;
  logic          rep_q, rep_d;
  logic          held_q, held_d;
  logic          rise, fall;

  assign rise = btn_lvl & ~prev_q;
  assign fall = ~btn_lvl & prev_q;

  // Saturating increment: dur never wraps back to a short duration.
  assign dur_inc = (dur_q == '1) ? dur_q : dur_q + 1'b1;

  always_ff @(posedge clk_1ms) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      prev_q  <= 1'b0;
      cnt_q   <= '0;
      dur_q   <= '0;
      hold_q  <= '0;
      press_q <= 1'b0;
      rel_q   <= 1'b0;
      long_q  <= 1'b0;
      rep_q   <= 1'b0;
      held_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      prev_q  <= btn_lvl;
      cnt_q   <= cnt_d;
      dur_q   <= dur_d;
      hold_q  <= hold_d;
      press_q <= press_d;
      rel_q   <= rel_d;
      long_q  <= long_d;
      rep_q   <= rep_d;
      held_q  <= held_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    dur_d   = dur_q;
    hold_d  = hold_q;
    press_d = 1'b0;
    rel_d   = 1'b0;
    long_d  = 1'b0;
    rep_d   = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (rise) begin
          state_d = S_PRESSED;
          press_d = 1'b1;
          cnt_d   = CW'(1);
          dur_d   = DW'(1);
        end
      end
      S_PRESSED: begin
        // The fall is checked first so a release on the threshold edge
        // suppresses long_press.
        if (fall) begin
          state_d = S_IDLE;
          rel_d   = 1'b1;
          hold_d  = dur_q;
          cnt_d   = '0;
        end else if (cnt_q == LONG_M1) begin
          state_d = S_LONG;
          long_d  = 1'b1;
          cnt_d   = '0;
          dur_d   = dur_inc;
        end else begin
          cnt_d   = cnt_q + 1'b1;
          dur_d   = dur_inc;
        end
      end
      S_LONG: begin
        if (fall) begin
          state_d = S_IDLE;
          rel_d   = 1'b1;
          hold_d  = dur_q;
          cnt_d   = '0;
        end else begin
          dur_d = dur_inc;
`ifdef BTN_REPEAT_EN
          if (cnt_q == REP_M1) begin
            rep_d = 1'b1;
            cnt_d = '0;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
`else
          cnt_d = '0;
`endif
        end
      end
      default: state_d = S_IDLE;
    endcase

    held_d = (state_d != S_IDLE);
  end

  assign press      = press_q;
  assign release_p  = rel_q;
  assign long_press = long_q;
  assign repeat_p   = rep_q;
  assign held       = held_q;
  assign hold_ms    = hold_q;

endmodule
